lsu_ctrl: RTL and testbench

- Load/store unit: the initiator that drives the data-memory port (addr/data/strobe/read_en/write_en in; data/data_vld out) from the memory stage.
- Accepts one RV32I load/store request per handshake from execute.
- Performs byte-lane steering, strobe generation and load sign/zero extension.
- Returns a registered response that feeds writeback's memory_data input.

---
 rtl/lsu_ctrl.sv | 121 ++++++++++++
 tb/tb_lsu_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit driving the data-memory port with lane steering and load extension.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats instead of rejecting them.
module lsu_ctrl #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [AWIDTH-1:0]     req_addr_i,
    input  logic [DWIDTH-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DWIDTH-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_misaligned_o,
    output logic [AWIDTH-1:0]     mem_addr_o,
    output logic [DWIDTH-1:0]     mem_data_o,
    output logic [DWIDTH/8-1:0]   mem_write_strb_o,
    output logic                  mem_read_en_o,
    output logic                  mem_write_en_o,
    input  logic [DWIDTH-1:0]     mem_data_i,
    input  logic                  mem_data_vld_i
);
    localparam int BYTES = DWIDTH / 8;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d, err_q, err_d, mis_q, mis_d, vld_q, vld_d;
    logic [2:0]          f3_q, f3_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d;
    logic                legal, misal, accept, acc, beat1, done, vld;
    logic [1:0]          off;
    logic [3:0]          mask;
    logic [2*BYTES-1:0]  wide_strb;
    logic [2*DWIDTH-1:0] wide_data;
    logic [DWIDTH-1:0]   lo, hi, raw, ext;

    always_comb begin
        legal = req_we_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                         : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = legal & ((req_funct3_i[1:0] == 2'b01 & req_addr_i[1:0] == 2'b11) |
                         (req_funct3_i[1:0] == 2'b10 & req_addr_i[1:0] != 2'b00));
        accept = state_q == IDLE & req_valid_i;
        acc = state_q == ACC0 | state_q == ACC1;
        beat1 = state_q == ACC1;
        off = addr_q[1:0];
        mask = f3_q[1:0] == 2'b00 ? 4'b0001 : f3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        wide_strb = (2*BYTES)'(mask) << off;
        wide_data = (2*DWIDTH)'(wdata_q) << {off, 3'b000};
        // Beat 1 supplies the upper word; beat 0 was parked in lo_q.
        lo = beat1 ? lo_q : mem_data_i;
        hi = beat1 ? mem_data_i : '0;
        vld = mem_data_vld_i & (~beat1 | vld_q);
        raw = DWIDTH'({hi, lo} >> {off, 3'b000});
        ext = f3_q == 3'b000 ? {{24{raw[7]}}, raw[7:0]} :
              f3_q == 3'b001 ? {{16{raw[15]}}, raw[15:0]} :
              f3_q == 3'b100 ? {24'b0, raw[7:0]} :
              f3_q == 3'b101 ? {16'b0, raw[15:0]} : raw;
        state_d = state_q == IDLE ? (req_valid_i ? ((~legal | (misal & ~SPLIT)) ? RESP : ACC0) : IDLE) :
                  state_q == ACC0 ? ((SPLIT & mis_q) ? ACC1 : RESP) :
                  state_q == ACC1 ? RESP : (rsp_ready_i ? IDLE : RESP);
        done = acc & state_d == RESP;
        we_d = accept ? req_we_i : we_q;
        f3_d = accept ? req_funct3_i : f3_q;
        addr_d = accept ? req_addr_i : addr_q;
        wdata_d = accept ? req_wdata_i : wdata_q;
        mis_d = accept ? misal : mis_q;
        err_d = accept ? ~legal : done ? (~we_q & ~vld) : err_q;
        rdata_d = accept ? '0 : done ? ((we_q | ~vld) ? '0 : ext) : rdata_q;
        lo_d = state_q == ACC0 ? mem_data_i : lo_q;
        vld_d = state_q == ACC0 ? mem_data_vld_i : vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            lo_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            lo_q    <= lo_d;
            vld_q   <= vld_d;
        end
    end

    assign req_ready_o      = state_q == IDLE & ~rst;
    assign rsp_valid_o      = state_q == RESP & ~rst;
    assign rsp_err_o        = rsp_valid_o & err_q;
    assign rsp_misaligned_o = rsp_valid_o & mis_q & ~SPLIT;
    assign rsp_rdata_o      = rdata_q;
    assign mem_addr_o       = (beat1 ? addr_q + AWIDTH'(4) : addr_q) & ~AWIDTH'(3);
    assign mem_read_en_o    = acc & ~we_q & ~rst;
    assign mem_write_en_o   = acc & we_q & ~rst;
    assign mem_write_strb_o = mem_write_en_o ? (beat1 ? wide_strb[2*BYTES-1:BYTES] : wide_strb[BYTES-1:0]) : '0;
    assign mem_data_o       = mem_write_en_o ? (beat1 ? wide_data[2*DWIDTH-1:DWIDTH] : wide_data[DWIDTH-1:0]) : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table-driven bench for lsu_ctrl against a small word-addressed memory.
module tb_lsu_ctrl;
    localparam logic [31:0] B = 32'h0100_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b1;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, rsp_misaligned_o;
    logic [31:0] rsp_rdata_o, mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_write_strb_o;
    logic        mem_read_en_o, mem_write_en_o, mem_data_vld_i;

    always #5 clk = ~clk;

    lsu_ctrl #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_misaligned_o(rsp_misaligned_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_strb_o(mem_write_strb_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i), .mem_data_vld_i(mem_data_vld_i)
    );

    // 16-word memory at B; anything else is out of range.
    logic [31:0] mem [16];
    logic        mem_init = 1'b1;
    logic        in_rng;
    assign in_rng = (mem_addr_o >= B) && (mem_addr_o < B + 32'd64);
    assign mem_data_vld_i = in_rng;
    assign mem_data_i = in_rng ? mem[mem_addr_o[5:2]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= i == 0 ? 32'hDEADBEEF : i == 1 ? 32'hAAAAAAAA : 32'h0;
        end else if (mem_write_en_o && in_rng) begin
            for (int i = 0; i < 4; i++) if (mem_write_strb_o[i]) mem[mem_addr_o[5:2]][8*i +: 8] <= mem_data_o[8*i +: 8];
        end
    end

    int pass_cnt = 0, total = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
        else pass_cnt++;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output logic ms,
                        output int lat, output int nrd, output int nwr,
                        output logic [3:0] st, output logic [31:0] md);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 0; nrd = 0; nwr = 0; st = '0; md = '0;
        do begin
            @(negedge clk);
            lat++;
            nrd += int'(mem_read_en_o);
            if (mem_write_en_o) begin
                nwr++;
                if (nwr == 1) begin st = mem_write_strb_o; md = mem_data_o; end
            end
        end while (!rsp_valid_o && lat < 10);
        if (!rsp_valid_o) lat = 99;
        rd = rsp_rdata_o; er = rsp_err_o; ms = rsp_misaligned_o;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] a, wd, rd; logic er, ms;
        int lat, nrd, nwr; logic [3:0] st; logic [31:0] md;
    } vec_t;

    vec_t v[18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, md, held;
        logic er, ms;
        logic [3:0] st;
        int lat, nrd, nwr, k;

        v[0]  = '{1'b0, 3'b010, B,      32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[1]  = '{1'b0, 3'b000, B+3,    32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[2]  = '{1'b0, 3'b100, B+3,    32'h0,        32'h000000DE, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[3]  = '{1'b0, 3'b001, B+2,    32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[4]  = '{1'b0, 3'b101, B,      32'h0,        32'h0000BEEF, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[5]  = '{1'b1, 3'b000, B+5,    32'h00000055, 32'h0,        1'b0, 1'b0, 2, 0, 1, 4'b0010, 32'h00005500};
        v[6]  = '{1'b0, 3'b010, B+4,    32'h0,        32'hAAAA55AA, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[7]  = '{1'b1, 3'b001, B+6,    32'h00001234, 32'h0,        1'b0, 1'b0, 2, 0, 1, 4'b1100, 32'h12340000};
        v[8]  = '{1'b0, 3'b010, B+4,    32'h0,        32'h123455AA, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[9]  = '{1'b0, 3'b010, B-16,   32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0, 4'h0, 32'h0};
        v[10] = '{1'b0, 3'b011, B,      32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0, 4'h0, 32'h0};
        v[11] = '{1'b1, 3'b100, B,      32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1, 0, 0, 4'h0, 32'h0};
        v[12] = '{1'b1, 3'b010, B+4,    32'h11223344, 32'h0,        1'b0, 1'b0, 2, 0, 1, 4'b1111, 32'h11223344};
        v[15] = '{1'b0, 3'b101, B+1,    32'h0,        32'h0000ADBE, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_SPLIT_EN
        v[13] = '{1'b0, 3'b010, B+2,    32'h0,        32'h3344DEAD, 1'b0, 1'b0, 3, 2, 0, 4'h0, 32'h0};
        v[14] = '{1'b0, 3'b001, B+3,    32'h0,        32'h000044DE, 1'b0, 1'b0, 3, 2, 0, 4'h0, 32'h0};
        v[16] = '{1'b1, 3'b001, B+3,    32'h0000BEEF, 32'h0,        1'b0, 1'b0, 3, 0, 2, 4'b1000, 32'hEF000000};
        v[17] = '{1'b0, 3'b010, B+4,    32'h0,        32'h112233BE, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
`else
        v[13] = '{1'b0, 3'b010, B+2,    32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0, 4'h0, 32'h0};
        v[14] = '{1'b0, 3'b001, B+3,    32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0, 4'h0, 32'h0};
        v[16] = '{1'b1, 3'b001, B+3,    32'h0000BEEF, 32'h0,        1'b0, 1'b1, 1, 0, 0, 4'h0, 32'h0};
        v[17] = '{1'b0, 3'b010, B+4,    32'h0,        32'h11223344, 1'b0, 1'b0, 2, 1, 0, 4'h0, 32'h0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready_o), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst rd_en", 32'(mem_read_en_o), 32'd0);
        chk("rst wr_en", 32'(mem_write_en_o), 32'd0);
        chk("rst strb", 32'(mem_write_strb_o), 32'd0);
        chk("rst rdata", rsp_rdata_o, 32'd0);
        chk("rst err", 32'(rsp_err_o), 32'd0);
        chk("rst mis", 32'(rsp_misaligned_o), 32'd0);
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst req_ready", 32'(req_ready_o), 32'd1);
        chk("post-rst rsp_valid", 32'(rsp_valid_o), 32'd0);

        // Backpressure: response must hold while rsp_ready_i is low
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = B;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_valid_o && k < 10);
        chk("bp latency", 32'(k), 32'd2);
        held = rsp_rdata_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp valid %0d", i), 32'(rsp_valid_o), 32'd1);
            chk($sformatf("bp rdata %0d", i), rsp_rdata_o, 32'hDEADBEEF);
            chk($sformatf("bp stable %0d", i), rsp_rdata_o, held);
            chk($sformatf("bp req_ready %0d", i), 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp release valid", 32'(rsp_valid_o), 32'd0);
        chk("bp release ready", 32'(req_ready_o), 32'd1);

        // Table-driven transactions
        for (int i = 0; i < 18; i++) begin
            xact(v[i].we, v[i].f3, v[i].a, v[i].wd, rd, er, ms, lat, nrd, nwr, st, md);
            chk($sformatf("v%0d rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d err", i), 32'(er), 32'(v[i].er));
            chk($sformatf("v%0d mis", i), 32'(ms), 32'(v[i].ms));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(v[i].lat));
            chk($sformatf("v%0d read beats", i), 32'(nrd), 32'(v[i].nrd));
            chk($sformatf("v%0d write beats", i), 32'(nwr), 32'(v[i].nwr));
            chk($sformatf("v%0d strb", i), 32'(st), 32'(v[i].st));
            chk($sformatf("v%0d mem_data", i), md, v[i].md);
        end

        // Reset during ACC0 of a store aborts the write
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = B + 8; req_wdata_i = 32'hFFFFFFFF;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort acc0 wr_en", 32'(mem_write_en_o), 32'd1);
        chk("abort acc0 strb", 32'(mem_write_strb_o), 32'hF);
        rst = 1'b1;
        #1;
        chk("abort rst wr_en", 32'(mem_write_en_o), 32'd0);
        chk("abort rst req_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        chk("abort mem word", mem[2], 32'h0);
        rst = 1'b0;
        #1;
        chk("abort idle valid", 32'(rsp_valid_o), 32'd0);
        chk("abort idle wr_en", 32'(mem_write_en_o), 32'd0);
        chk("abort idle rd_en", 32'(mem_read_en_o), 32'd0);
        chk("abort idle strb", 32'(mem_write_strb_o), 32'd0);
        chk("abort idle rdata", rsp_rdata_o, 32'd0);
        chk("abort idle err", 32'(rsp_err_o), 32'd0);
        chk("abort idle ready", 32'(req_ready_o), 32'd1);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            k += int'(mem_write_en_o) + int'(rsp_valid_o);
        end
        chk("abort quiet", 32'(k), 32'd0);
        xact(1'b0, 3'b010, B + 8, 32'h0, rd, er, ms, lat, nrd, nwr, st, md);
        chk("abort readback", rd, 32'h0);
        chk("abort readback latency", 32'(lat), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
